// File: rtl/db15_pkg.sv
// Shared constants, pad bit layout and FSM states for the DB15 joystick chain emulator.
package db15_pkg;

  localparam int unsigned DEF_CHAIN_LEN = 24;
  localparam int unsigned BTN_W         = 12;
  localparam int unsigned P1_BASE       = 0;
  localparam int unsigned P2_BASE       = 12;

  localparam int unsigned BTN_RIGHT  = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_A      = 4;
  localparam int unsigned BTN_B      = 5;
  localparam int unsigned BTN_X      = 6;
  localparam int unsigned BTN_Y      = 7;
  localparam int unsigned BTN_START  = 8;
  localparam int unsigned BTN_SELECT = 9;
  localparam int unsigned BTN_C      = 10;
  localparam int unsigned BTN_Z      = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Places both pads at their chain offsets (active-high pressed)
  function automatic logic [2*BTN_W-1:0] pack_pads(input logic [BTN_W-1:0] p1,
                                                   input logic [BTN_W-1:0] p2);
    logic [2*BTN_W-1:0] v;
    v = '0;
    v[P1_BASE +: BTN_W] = p1;
    v[P2_BASE +: BTN_W] = p2;
    return v;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous reader pin, with a registered
// level and a one-cycle rising-edge pulse aligned to that level.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_50,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      level  <= RESET_VAL;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
    end
  end

endmodule

// File: rtl/db15_joy_emulator.sv
// Device end of a serial DB15 joystick adapter: two 12-button pads presented
// as one active-low parallel-load shift chain clocked by the host reader.
module db15_joy_emulator
  import db15_pkg::*;
#(
  parameter int unsigned CHAIN_LEN   = DEF_CHAIN_LEN,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        SERIAL_IN   = 1'b1
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic [BTN_W-1:0] p1_btn,
  input  logic [BTN_W-1:0] p2_btn,
  input  logic             joy_load,
  input  logic             joy_clk,
  output logic             joy_data,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

  logic                 load_lvl;
  logic                 load_rise;
  logic                 clk_lvl;
  logic                 clk_rise;
  state_e               state;
  logic [CHAIN_LEN-1:0] sr;
  logic [CNT_W-1:0]     bit_cnt;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_load_sync (
    .clk_50 (clk_50),
    .reset  (reset),
    .din    (joy_load),
    .level  (load_lvl),
    .rise   (load_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
    .clk_50 (clk_50),
    .reset  (reset),
    .din    (joy_clk),
    .level  (clk_lvl),
    .rise   (clk_rise)
  );

  // Load level overrides everything, so a load coinciding with a clock edge never shifts
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      sr         <= '1;
      bit_cnt    <= '0;
      joy_data   <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      joy_data   <= sr[0];
      if (!load_lvl) begin
        state   <= ST_LOAD;
        sr      <= CHAIN_LEN'(~pack_pads(p1_btn, p2_btn));
        bit_cnt <= '0;
        overrun <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: ;
          ST_LOAD: begin
            if (load_rise) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (clk_rise) begin
              sr      <= {SERIAL_IN, sr[CHAIN_LEN-1:1]};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
                state      <= ST_DONE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            // Reader clocked past the end of the frame; count stays saturated
            if (clk_rise) begin
              sr      <= {SERIAL_IN, sr[CHAIN_LEN-1:1]};
              overrun <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic unused_clk_lvl;
  assign unused_clk_lvl = clk_lvl;

endmodule
